riscv_data_mem_responder: RTL
=============================

// Module: riscv_data_mem_responder
// PURPOSE
// - Memory-side responder for the core data interface (req/gnt/rvalid protocol driven by the LSU).
// - Word-addressed SRAM model/adapter with byte enables, range-error reporting and optional AMO execution.
// - Sits between a core's data port and a private scratchpad (TCDM-style bank).
// - Fixed 1-cycle response latency; supports back-to-back requests.
// PARAMETERS
// - NumWords   1024   memory depth in 32-bit words; must be a power of 2, >= 2
// - BaseAddr   32'h0  byte address of word 0; must be aligned to NumWords*4
// PORTS
// - clk_i          in   1   clock, rising edge
// - rst_i          in   1   asynchronous reset, active-high
// - data_req_i     in   1   request valid
// - data_gnt_o     out  1   grant; request accepted this cycle
// - data_addr_i    in   32  byte address; bits [1:0] ignored
// - data_we_i      in   1   1 = write, 0 = read
// - data_be_i      in   4   byte enables, bit n -> byte lane n
// - data_wdata_i   in   32  write data, already lane-aligned by the initiator
// - data_atop_i    in   6   atomic op; [5] = AMO valid, [4:0] = RISC-V funct5
// - data_buffer_i  in   1   bufferable hint; ignored
// - data_rvalid_o  out  1   response valid, exactly one per grant
// - data_rdata_o   out  32  read data / AMO old value
// - data_err_o     out  1   error, asserted in the grant cycle of a faulting request
// BEHAVIOUR
// - Reset (async, rst_i=1): state=Idle; data_rvalid_o=0; data_rdata_o=0; pending flags cleared. Memory contents not reset.
// - data_gnt_o is combinational: data_req_i && state==Idle. The initiator holds its request until granted.
// - Index = (data_addr_i - BaseAddr) >> 2.
// - Out of range: addr < BaseAddr or index >= NumWords.
// - Error: out of range, or an unsupported atop (see CONFIGURATION).
// - Errored grant: data_err_o=1 in the same cycle; no memory access; rvalid next cycle with rdata=0.
// - Read, granted at cycle t: rvalid=1 at t+1; rdata = full word mem[index]. The initiator masks and shifts.
// - Write, granted at t: only be-enabled lanes are updated, visible at t+1. rvalid=1 at t+1 with rdata=0.
// - be=0 write: no change, still responded. rdata_o holds its last value when rvalid=0.
// - Back-to-back: a new grant is allowed in the same cycle as the previous rvalid, giving full throughput.
// - Read-after-write to the same word on consecutive grants returns the new data.
// - FSM states:
//   - Idle: grant any request. A granted, error-free AMO goes to AmoWrite.
//   - AmoWrite (1 cycle): gnt=0. result=f(old,wdata) is written to the word; rvalid=1 with rdata=old. Then back to Idle.
// - A request arriving in AmoWrite waits and is granted in the next Idle cycle.
// - Reset asserted mid-AMO: the write is aborted, no rvalid is issued, and the FSM returns to Idle.
// - Arithmetic: 32-bit wrap-around add. MIN/MAX are signed, MINU/MAXU unsigned. Width is always 32.
// CONFIGURATION
// - Macro DATA_RESP_ATOP_EN.
// - Defined: AMO funct5 codes are supported: ADD 00000, SWAP 00001, XOR 00100, OR 01000, AND 01100,
//   MIN 10000, MAX 10100, MINU 11000, MAXU 11100.
// - Defined: an AMO with be!=4'hF, or any other funct5 (including LR 00010 / SC 00011), is an error.
// - Defined: data_we_i is ignored when atop[5]=1.
// - Not defined: no AmoWrite state and no ALU. Any request with atop[5]=1 is an error (err, no write, rdata=0).
// - Not defined: atop[5]=0 requests behave identically in both builds.
// TESTING
// - Write 0xDEADBEEF at word 4, be=F; read word 4 -> gnt same cycle; rvalid next cycle; rdata=0xDEADBEEF.
// - Write be=4'b0100, wdata=0x00AA0000, to a word holding 0x11223344 -> read returns 0x11AA3344.
// - Back-to-back: write 0x5 then read, same address, consecutive cycles -> two gnts, two rvalids; read rdata=0x5.
// - Address BaseAddr+NumWords*4 -> gnt=1 and err=1 in the same cycle; rvalid next cycle with rdata=0; memory unchanged.
// - With DATA_RESP_ATOP_EN, word=0xFFFFFFFF, AMOADD wdata=2 -> rvalid with 0xFFFFFFFF; word becomes 0x1.
// - With DATA_RESP_ATOP_EN, gnt=0 during AmoWrite; AMOMINU(0x80000000,1) leaves 1; AMOMIN leaves 0x80000000.
// - Without DATA_RESP_ATOP_EN, the same AMOADD -> err=1; word unchanged.
// - Reset pulse during AmoWrite -> no rvalid; word not updated; next read is served normally.

Source files
------------

// File: rtl/riscv_data_mem_responder.sv
// Core data-port responder backed by a word-addressed scratchpad: byte-enable writes,
// range errors, 1-cycle responses. Define DATA_RESP_ATOP_EN to execute RISC-V AMOs.
module riscv_data_mem_responder #(
    parameter int unsigned NumWords = 1024,
    parameter logic [31:0] BaseAddr = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    input  logic [5:0]  data_atop_i,
    input  logic        data_buffer_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int unsigned IdxW      = $clog2(NumWords);
    localparam logic [29:0] NumWordsW = 30'(NumWords);

    logic [31:0]     mem [NumWords];
    logic [31:0]     offset;
    logic [IdxW-1:0] idx;
    logic            in_range;
    logic            is_amo;
    logic            atop_err;
    logic            req_err;
    logic            idle;

    logic            mem_we;
    logic [IdxW-1:0] mem_idx;
    logic [3:0]      mem_be;
    logic [31:0]     mem_wdata;

    assign offset   = data_addr_i - BaseAddr;
    assign idx      = offset[IdxW+1:2];
    assign in_range = (data_addr_i >= BaseAddr) && (offset[31:2] < NumWordsW);
    assign is_amo   = data_atop_i[5];

`ifdef DATA_RESP_ATOP_EN
    typedef enum logic {IDLE, AMO_WRITE} state_e;

    state_e          state;
    logic [IdxW-1:0] amo_idx;
    logic [4:0]      amo_op;
    logic [31:0]     amo_wdata;

    function automatic logic amo_supported(input logic [4:0] op);
        case (op)
            5'b00000, 5'b00001, 5'b00100, 5'b01000, 5'b01100,
            5'b10000, 5'b10100, 5'b11000, 5'b11100: amo_supported = 1'b1;
            default:                                 amo_supported = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] amo_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            5'b00000: amo_alu = a + b;
            5'b00001: amo_alu = b;
            5'b00100: amo_alu = a ^ b;
            5'b01000: amo_alu = a | b;
            5'b01100: amo_alu = a & b;
            5'b10000: amo_alu = ($signed(a) < $signed(b)) ? a : b;
            5'b10100: amo_alu = ($signed(a) > $signed(b)) ? a : b;
            5'b11000: amo_alu = (a < b) ? a : b;
            5'b11100: amo_alu = (a > b) ? a : b;
            default:  amo_alu = a;
        endcase
    endfunction

    assign atop_err = is_amo && ((data_be_i != 4'hF) || !amo_supported(data_atop_i[4:0]));
    assign idle     = (state == IDLE);

    logic unused_sigs;
    assign unused_sigs = ^{data_buffer_i, offset[1:0]};
`else
    assign atop_err = is_amo;
    assign idle     = 1'b1;

    logic unused_sigs;
    assign unused_sigs = ^{data_buffer_i, offset[1:0], data_atop_i[4:0]};
`endif

    assign req_err    = !in_range || atop_err;
    assign data_gnt_o = data_req_i && idle;
    assign data_err_o = data_gnt_o && req_err;

    // Single memory write port: plain writes in the grant cycle, AMO results in AmoWrite.
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = idx;
        mem_be    = data_be_i;
        mem_wdata = data_wdata_i;
        if (data_gnt_o && !req_err && data_we_i && !is_amo) begin
            mem_we = 1'b1;
        end
`ifdef DATA_RESP_ATOP_EN
        // rdata still holds the old word during AmoWrite, so it feeds the ALU.
        if (state == AMO_WRITE) begin
            mem_we    = 1'b1;
            mem_idx   = amo_idx;
            mem_be    = 4'hF;
            mem_wdata = amo_alu(amo_op, data_rdata_o, amo_wdata);
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response path and AMO sequencing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_rvalid_o <= 1'b0;
            data_rdata_o  <= '0;
`ifdef DATA_RESP_ATOP_EN
            state         <= IDLE;
            amo_idx       <= '0;
            amo_op        <= '0;
            amo_wdata     <= '0;
`endif
        end else begin
            data_rvalid_o <= 1'b0;
            if (data_gnt_o) begin
                data_rvalid_o <= 1'b1;
                if (req_err || (data_we_i && !is_amo)) begin
                    data_rdata_o <= '0;
                end else begin
                    data_rdata_o <= mem[idx];
                end
`ifdef DATA_RESP_ATOP_EN
                if (is_amo && !req_err) begin
                    state     <= AMO_WRITE;
                    amo_idx   <= idx;
                    amo_op    <= data_atop_i[4:0];
                    amo_wdata <= data_wdata_i;
                end
`endif
            end
`ifdef DATA_RESP_ATOP_EN
            if (state == AMO_WRITE) begin
                state <= IDLE;
            end
`endif
        end
    end

endmodule
